// File: rtl/afu_arb_pkg.sv
// Shared types for the AFU memory-port arbiter: FSM states, arbitration modes
// and the latched transaction record.
package afu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned ARB_RR   = 0;
    localparam int unsigned ARB_PRIO = 1;

    // Upper bounds for the transaction record; the top narrows to its own widths.
    localparam int unsigned CH_IDX_W   = 3;
    localparam int unsigned ADDR_MAX_W = 64;
    localparam int unsigned DATA_MAX_W = 512;

    typedef struct packed {
        logic [CH_IDX_W-1:0]   ch;
        logic                  is_write;
        logic [ADDR_MAX_W-1:0] addr;
        logic [DATA_MAX_W-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: round-robin search from ptr_i, or fixed
// priority with the lowest index winning.
module rr_arbiter
    import afu_arb_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ARB_MODE = ARB_RR,
    localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_idx_o,
    output logic              any_o
);

    logic [CH_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == ARB_PRIO) begin
                idx = CH_W'(i);
            end else begin
                idx = CH_W'((32'(ptr_i) + i) % NUM_CH);
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afu_mem_arbiter.sv
// Shares the single AFU memory port between NUM_CH requesters, one transaction
// in flight, with per-channel grant/completion/timeout pulses.
module afu_mem_arbiter
    import afu_arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned ARB_MODE    = ARB_RR,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_rd_req,
    input  logic [NUM_CH-1:0]        ch_wr_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_rd_valid,
    output logic [NUM_CH-1:0]        ch_wr_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    input  logic                     buffer_addr_valid,
    output logic                     mem_rd_req,
    output logic                     mem_wr_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_data_valid,
    input  logic                     mem_write_done,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

    arb_state_e          state_q, state_d;
    txn_t                txn_q, txn_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   rd_valid_q, rd_valid_d;
    logic [NUM_CH-1:0]   wr_done_q, wr_done_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                busy_q;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_any;
    logic                launch;
    logic                rsp_hit;
    logic                timeout_hit;
    logic [NUM_CH-1:0]   owner_oh;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_rr_arbiter (
        .req_i     (ch_rd_req | ch_wr_req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign rsp_hit     = txn_q.is_write ? mem_write_done : mem_data_valid;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign owner_oh    = NUM_CH'(1) << txn_q.ch;

    // Next-state and registered-output logic; RESP may launch directly so the
    // next grant can follow a completion pulse by one cycle.
    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = '0;
        rd_valid_d = '0;
        wr_done_d  = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        launch     = 1'b0;

        case (state_q)
            IDLE: begin
                launch = buffer_addr_valid && arb_any;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (rsp_hit) begin
                    state_d = RESP;
                    if (txn_q.is_write) begin
                        wr_done_d = owner_oh;
                    end else begin
                        rd_valid_d = owner_oh;
                        rdata_d    = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = owner_oh;
                end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                launch  = buffer_addr_valid && arb_any;
            end
            default: state_d = IDLE;
        endcase

        // Read wins when a channel raises both; its write stays pending.
        if (launch) begin
            state_d        = ISSUE;
            txn_d.ch       = CH_IDX_W'(arb_idx);
            txn_d.is_write = !ch_rd_req[arb_idx];
            txn_d.addr     = ADDR_MAX_W'(ch_addr[arb_idx*ADDR_W +: ADDR_W]);
            txn_d.wdata    = DATA_MAX_W'(ch_wdata[arb_idx*DATA_W +: DATA_W]);
            grant_d        = arb_gnt;
            mem_rd_d       = ch_rd_req[arb_idx];
            mem_wr_d       = !ch_rd_req[arb_idx];
            if (ARB_MODE == ARB_RR) begin
                ptr_d = CH_W'((32'(arb_idx) + 1) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            txn_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            rd_valid_q <= '0;
            wr_done_q  <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign ch_grant    = grant_q;
    assign ch_rd_valid = rd_valid_q;
    assign ch_wr_done  = wr_done_q;
    assign ch_err      = err_q;
    assign ch_rdata    = rdata_q;
    assign mem_rd_req  = mem_rd_q;
    assign mem_wr_req  = mem_wr_q;
    assign mem_addr    = ADDR_W'(txn_q.addr);
    assign mem_wdata   = DATA_W'(txn_q.wdata);
    assign busy        = busy_q;

endmodule

// File: tb/tb_afu_mem_arbiter.sv
// Directed bench for afu_mem_arbiter: a round-robin and a fixed-priority
// instance share one stimulus stream.
module tb_afu_mem_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 512;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    rd_req, wr_req;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic              buf_v, dv, wd;
    logic [DW-1:0]     rdata_in;

    logic [NCH-1:0] grant_a, rdv_a, wrd_a, err_a;
    logic [DW-1:0]  rdata_a, mwd_a;
    logic [AW-1:0]  maddr_a;
    logic           mrd_a, mwr_a, busy_a;

    logic [NCH-1:0] grant_b, rdv_b, wrd_b, err_b;
    logic [DW-1:0]  rdata_b, mwd_b;
    logic [AW-1:0]  maddr_b;
    logic           mrd_b, mwr_b, busy_b;

    int checks = 0;
    int fails  = 0;

    afu_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(16)) u_rr (
        .clk(clk), .rst_n(rst_n), .ch_rd_req(rd_req), .ch_wr_req(wr_req),
        .ch_addr(addr), .ch_wdata(wdata), .ch_grant(grant_a), .ch_rd_valid(rdv_a),
        .ch_wr_done(wrd_a), .ch_err(err_a), .ch_rdata(rdata_a),
        .buffer_addr_valid(buf_v), .mem_rd_req(mrd_a), .mem_wr_req(mwr_a),
        .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_data_valid(dv),
        .mem_write_done(wd), .mem_rdata(rdata_in), .busy(busy_a)
    );

    afu_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(16)) u_pr (
        .clk(clk), .rst_n(rst_n), .ch_rd_req(rd_req), .ch_wr_req(wr_req),
        .ch_addr(addr), .ch_wdata(wdata), .ch_grant(grant_b), .ch_rd_valid(rdv_b),
        .ch_wr_done(wrd_b), .ch_err(err_b), .ch_rdata(rdata_b),
        .buffer_addr_valid(buf_v), .mem_rd_req(mrd_b), .mem_wr_req(mwr_b),
        .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_data_valid(dv),
        .mem_write_done(wd), .mem_rdata(rdata_in), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, check pulse invariants.
    task automatic step();
        logic inv;
        @(posedge clk);
        #1;
        inv = $onehot0({grant_a, rdv_a, wrd_a, err_a}) && !(mrd_a && mwr_a)
           && $onehot0({grant_b, rdv_b, wrd_b, err_b}) && !(mrd_b && mwr_b);
        chk("invariant", DW'(inv), DW'(1));
    endtask

    logic [NCH-1:0] exp_oh;
    logic [DW-1:0]  pat;
    logic           seen3;

    initial begin
        rst_n = 1'b0; rd_req = '0; wr_req = '0; addr = '0; wdata = '0;
        buf_v = 1'b1; dv = 1'b0; wd = 1'b0; rdata_in = '0;
        step(); step();
        chk("rst_grant_a", DW'(grant_a), '0);
        chk("rst_pulses_a", DW'({rdv_a, wrd_a, err_a}), '0);
        chk("rst_rdata_a", rdata_a, '0);
        chk("rst_mem_a", DW'({mrd_a, mwr_a, busy_a, maddr_a}), '0);
        chk("rst_mwdata_a", mwd_a, '0);
        chk("rst_all_b", DW'({grant_b, rdv_b, wrd_b, err_b, mrd_b, mwr_b, busy_b, maddr_b}), '0);
        chk("rst_data_b", rdata_b | mwd_b, '0);
        rst_n = 1'b1;

        // Fairness: all channels hold read requests, memory answers 2 cycles after grant.
        for (int k = 0; k < NCH; k++) addr[k*AW +: AW] = AW'(32'h100 * (k + 1));
        rd_req = 4'hF;
        step();
        for (int k = 0; k < 6; k++) begin
            exp_oh = 4'(1 << (k % 4));
            chk("rr_grant", DW'(grant_a), DW'(exp_oh));
            chk("prio_grant", DW'(grant_b), DW'(4'b0001));
            chk("rr_mem_rd", DW'(mrd_a), DW'(1));
            chk("rr_addr", DW'(maddr_a), DW'(32'h100 * ((k % 4) + 1)));
            if (k == 5) rd_req = '0;
            step(); step();
            dv = 1'b1; pat = {16{32'(k + 7)}}; rdata_in = pat;
            step();
            dv = 1'b0;
            chk("rr_rd_valid", DW'(rdv_a), DW'(exp_oh));
            chk("rr_rdata", rdata_a, pat);
            chk("prio_rd_valid", DW'(rdv_b), DW'(4'b0001));
            step();
        end
        chk("rr_idle", DW'(busy_a), '0);

        // Single read from ch1, response 5 cycles after the memory request.
        addr = '0; addr[1*AW +: AW] = 32'h40;
        rd_req = 4'b0010;
        step();
        chk("rd_grant", DW'(grant_a), DW'(4'b0010));
        chk("rd_mem_req", DW'({mrd_a, mwr_a}), DW'(2'b10));
        chk("rd_addr", DW'(maddr_a), DW'(32'h40));
        chk("rd_busy", DW'(busy_a), DW'(1));
        rd_req = '0;
        step();
        chk("rd_grant_once", DW'({grant_a, mrd_a}), '0);
        step(); step(); step(); step();
        dv = 1'b1; pat = {64{8'hAB}}; rdata_in = pat;
        step();
        dv = 1'b0;
        chk("rd_valid", DW'(rdv_a), DW'(4'b0010));
        chk("rd_data", rdata_a, pat);
        step();
        chk("rd_valid_once", DW'(rdv_a), '0);
        chk("rd_idle", DW'(busy_a), '0);

        // ch2 holds read and write: read first, write follows right after RESP.
        addr[2*AW +: AW] = 32'h80;
        wdata[2*DW +: DW] = {16{32'hDEADBEEF}};
        rd_req = 4'b0100; wr_req = 4'b0100;
        step();
        chk("rw_grant_rd", DW'(grant_a), DW'(4'b0100));
        chk("rw_mem_rd", DW'({mrd_a, mwr_a}), DW'(2'b10));
        rd_req = '0;
        step();
        dv = 1'b1; pat = {64{8'h5A}}; rdata_in = pat;
        step();
        dv = 1'b0;
        chk("rw_rd_valid", DW'(rdv_a), DW'(4'b0100));
        chk("rw_rdata", rdata_a, pat);
        step();
        chk("rw_grant_wr", DW'(grant_a), DW'(4'b0100));
        chk("rw_mem_wr", DW'({mrd_a, mwr_a}), DW'(2'b01));
        chk("rw_wdata", mwd_a, {16{32'hDEADBEEF}});
        chk("rw_addr", DW'(maddr_a), DW'(32'h80));
        wr_req = '0;
        step();
        dv = 1'b1;
        step();
        dv = 1'b0;
        chk("rw_mismatch_ignored", DW'({rdv_a, wrd_a}), '0);
        chk("rw_still_busy", DW'(busy_a), DW'(1));
        wd = 1'b1;
        step();
        wd = 1'b0;
        chk("rw_wr_done", DW'(wrd_a), DW'(4'b0100));
        chk("rw_wdata_hold", mwd_a, {16{32'hDEADBEEF}});
        step();
        chk("rw_idle", DW'(busy_a), '0);

        // Gating with ch0 pending; ch3 raises and withdraws while gated.
        buf_v = 1'b0; rd_req = 4'b0001; seen3 = 1'b0;
        addr[0 +: AW] = 32'h200;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) rd_req[3] = 1'b1;
            if (i == 6) rd_req[3] = 1'b0;
            step();
            chk("gate_no_req", DW'({mrd_a, mwr_a, grant_a}), '0);
        end
        buf_v = 1'b1;
        step();
        chk("gate_grant", DW'(grant_a), DW'(4'b0001));
        chk("gate_addr", DW'(maddr_a), DW'(32'h200));
        seen3 |= grant_a[3];
        rd_req = '0;
        step();
        dv = 1'b1;
        step();
        dv = 1'b0;
        chk("gate_rd_valid", DW'(rdv_a), DW'(4'b0001));
        seen3 |= rdv_a[3];
        step();
        seen3 |= grant_a[3] | rdv_a[3] | wrd_a[3] | err_a[3];
        chk("withdraw_ch3_silent", DW'(seen3), '0);

        // Timeout on a ch1 write with no memory response.
        wr_req = 4'b0010;
        step();
        chk("to_grant", DW'(grant_a), DW'(4'b0010));
        chk("to_mem_wr", DW'(mwr_a), DW'(1));
        wr_req = '0;
        for (int i = 1; i <= 16; i++) step();
        chk("to_no_err_early", DW'(err_a), '0);
        chk("to_busy", DW'(busy_a), DW'(1));
        step();
        chk("to_err", DW'(err_a), DW'(4'b0010));
        chk("to_no_done", DW'({wrd_a, rdv_a}), '0);
        rd_req = 4'b0001;
        step();
        chk("to_next_grant", DW'(grant_a), DW'(4'b0001));
        rd_req = '0;
        step();
        dv = 1'b1; pat = {64{8'h33}}; rdata_in = pat;
        step();
        dv = 1'b0;
        chk("to_next_rd_valid", DW'(rdv_a), DW'(4'b0001));
        chk("to_next_rdata", rdata_a, pat);
        step();

        // Reset while waiting on a read; late response ignored; ptr back to 0.
        rd_req = 4'b0100;
        step();
        chk("rw2_grant", DW'(grant_a), DW'(4'b0100));
        rd_req = '0;
        step();
        rst_n = 1'b0;
        step();
        chk("wrst_outs", DW'({grant_a, rdv_a, wrd_a, err_a, mrd_a, mwr_a, busy_a}), '0);
        chk("wrst_addr", DW'(maddr_a), '0);
        chk("wrst_rdata", rdata_a, '0);
        rst_n = 1'b1; dv = 1'b1;
        step();
        dv = 1'b0;
        chk("wrst_late_ignored", DW'({rdv_a, busy_a}), '0);
        rd_req = 4'b1010;
        step();
        chk("wrst_ptr0_grant", DW'(grant_a), DW'(4'b0010));
        chk("wrst_prio_grant", DW'(grant_b), DW'(4'b0010));
        rd_req = '0;
        step();
        dv = 1'b1;
        step();
        dv = 1'b0;
        chk("wrst_rd_valid", DW'(rdv_a), DW'(4'b0010));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
